// File: rtl/fft8_scheduler.sv
// fft8_scheduler: sequences one shared radix-2 butterfly through an in-place 8-point DIT FFT,
// loading samples bit-reversed and unloading bins in natural order.
module fft8_scheduler #(
  parameter int N      = 4,
  parameter int BF_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2**N-1:0] in_r,
  input  logic [2**N-1:0] in_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2**N-1:0] out_r,
  output logic [2**N-1:0] out_i,
  output logic            out_last,
  output logic [2**N-1:0] bf_a_r,
  output logic [2**N-1:0] bf_a_i,
  output logic [2**N-1:0] bf_b_r,
  output logic [2**N-1:0] bf_b_i,
  output logic [1:0]      bf_tw,
  output logic            bf_start,
  input  logic [2**N-1:0] bf_y0_r,
  input  logic [2**N-1:0] bf_y0_i,
  input  logic [2**N-1:0] bf_y1_r,
  input  logic [2**N-1:0] bf_y1_i,
  output logic            busy
);
  localparam int W  = 2**N;
  localparam int LW = BF_LAT > 0 ? $clog2(BF_LAT + 1) : 1;

  typedef enum logic [1:0] {S_LOAD, S_COMP, S_UNLD} state_t;

  state_t        r_state, w_next;
  logic [W-1:0]  r_mr [8];
  logic [W-1:0]  r_mi [8];
  logic [2:0]    r_idx, w_rev, w_a, w_b;
  logic [1:0]    r_stg, r_bf, w_tw;
  logic [LW-1:0] r_ph;
  logic          w_acc, w_oxf, w_cap, w_comp;

  assign w_rev = {r_idx[0], r_idx[1], r_idx[2]};
  // pair for butterfly k of stage s: insert a zero at bit s of k for a, set that bit for b
  assign w_a   = r_stg == 2'd0 ? {r_bf, 1'b0} : r_stg == 2'd1 ? {r_bf[1], 1'b0, r_bf[0]} : {1'b0, r_bf};
  assign w_b   = w_a | (3'd1 << r_stg);
  assign w_tw  = r_stg == 2'd0 ? 2'd0 : r_stg == 2'd1 ? {r_bf[0], 1'b0} : r_bf;
  assign w_acc = in_valid && in_ready;
  assign w_oxf = out_valid && out_ready;
  assign w_cap = r_state == S_COMP && r_ph == LW'(BF_LAT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_LOAD;
      r_idx   <= '0;
      r_stg   <= '0;
      r_bf    <= '0;
      r_ph    <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc || w_oxf) r_idx <= r_idx + 1'b1;
      if (r_state == S_COMP) begin
        r_ph <= w_cap ? '0 : r_ph + 1'b1;
        if (w_cap) r_bf <= r_bf + 1'b1;
        if (w_cap && r_bf == 2'd3) r_stg <= r_stg == 2'd2 ? 2'd0 : r_stg + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:  if (w_acc && r_idx == 3'd7) w_next = S_COMP;
      S_COMP:  if (w_cap && r_stg == 2'd2 && r_bf == 2'd3) w_next = S_UNLD;
      S_UNLD:  if (w_oxf && r_idx == 3'd7) w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = rst && r_state == S_LOAD;
    out_valid = rst && r_state == S_UNLD;
    busy      = rst && r_state != S_LOAD;
    w_comp    = rst && r_state == S_COMP;
    bf_start  = w_comp && r_ph == '0;
    bf_a_r    = w_comp ? r_mr[w_a] : '0;
    bf_a_i    = w_comp ? r_mi[w_a] : '0;
    bf_b_r    = w_comp ? r_mr[w_b] : '0;
    bf_b_i    = w_comp ? r_mi[w_b] : '0;
    bf_tw     = w_comp ? w_tw : 2'd0;
    out_r     = r_mr[r_idx];
    out_i     = r_mi[r_idx];
    out_last  = out_valid && r_idx == 3'd7;
  end

  // storage is never cleared; every frame rewrites all eight entries before use
  always_ff @(posedge clk) begin
    if (rst && w_acc) begin
      r_mr[w_rev] <= in_r;
      r_mi[w_rev] <= in_i;
    end
    if (rst && w_cap) begin
      r_mr[w_a] <= bf_y0_r;
      r_mi[w_a] <= bf_y0_i;
      r_mr[w_b] <= bf_y1_r;
      r_mi[w_b] <= bf_y1_i;
    end
  end
endmodule
